vga_timing_gen: RTL and testbench

//  Parametrised VGA/SVGA raster timing generator.
//  It generalises the fixed 640x480 sync unit to any mode through parameters.

---
 rtl/vga_timing_gen.sv | 196 +++++++++++++++++++
 tb/tb_vga_timing_gen.sv | 228 ++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : vga_timing_gen
//  Description : Parametrised VGA/SVGA raster timing generator with pixel
//                clock divider, sync polarity control, a sync/blank delay
//                line for pixel-pipeline alignment, line/frame strobes,
//                a frame counter and a run enable.
//  Revision    : 1.0  initial release
// ============================================================================
module vga_timing_gen #(
    parameter int H_ACTIVE   = 640,
    parameter int H_FP       = 16,
    parameter int H_SYNC     = 96,
    parameter int H_BP       = 48,
    parameter int V_ACTIVE   = 480,
    parameter int V_FP       = 10,
    parameter int V_SYNC     = 2,
    parameter int V_BP       = 33,
    parameter int DIV        = 2,
    parameter int HS_ACT_LOW = 1,
    parameter int VS_ACT_LOW = 1,
    parameter int SYNC_DELAY = 0,
    parameter int COORD_W    = 10,
    parameter int FRAME_W    = 8
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               enable,
    output logic               p_tick,
    output logic [COORD_W-1:0] pixel_x,
    output logic [COORD_W-1:0] pixel_y,
    output logic               video_on,
    output logic               hsync,
    output logic               vsync,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [DIV_W-1:0]   DIV_LAST   = DIV_W'(DIV - 1);
    localparam logic [DIV_W-1:0]   DIV_ONE    = DIV_W'(1);
    localparam logic [COORD_W-1:0] COORD_ONE  = COORD_W'(1);
    localparam logic [FRAME_W-1:0] FRAME_ONE  = FRAME_W'(1);
    localparam logic [COORD_W-1:0] H_LAST     = COORD_W'(H_TOT - 1);
    localparam logic [COORD_W-1:0] V_LAST     = COORD_W'(V_TOT - 1);
    localparam logic [COORD_W-1:0] H_ACT_END  = COORD_W'(H_ACTIVE);
    localparam logic [COORD_W-1:0] V_ACT_END  = COORD_W'(V_ACTIVE);
    localparam logic [COORD_W-1:0] HS_FIRST   = COORD_W'(H_ACTIVE + H_FP);
    localparam logic [COORD_W-1:0] HS_LAST    = COORD_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [COORD_W-1:0] VS_FIRST   = COORD_W'(V_ACTIVE + V_FP);
    localparam logic [COORD_W-1:0] VS_LAST    = COORD_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    // Reject modes whose counters would not fit, and a zero divider.
    generate
        if ((H_TOT - 1) >= (1 << COORD_W)) begin : g_err_h_range
            $error("vga_timing_gen: H total does not fit in COORD_W bits");
        end
        if ((V_TOT - 1) >= (1 << COORD_W)) begin : g_err_v_range
            $error("vga_timing_gen: V total does not fit in COORD_W bits");
        end
        if (DIV < 1) begin : g_err_div
            $error("vga_timing_gen: DIV must be at least 1");
        end
        if ((SYNC_DELAY < 0) || (SYNC_DELAY > 15)) begin : g_err_delay
            $error("vga_timing_gen: SYNC_DELAY must be 0..15");
        end
    endgenerate

    logic [DIV_W-1:0]   div_cnt;
    logic [COORD_W-1:0] h_cnt;
    logic [COORD_W-1:0] v_cnt;
    logic [COORD_W-1:0] h_next;
    logic [COORD_W-1:0] v_next;
    logic               advance;
    logic               h_wrap;
    logic               v_wrap;
    logic               vid_next;
    logic               hs_next;
    logic               vs_next;

    // Aligned (undelayed) sync/blank, active-high, registered with the counters.
    logic               vid_s0;
    logic               hs_s0;
    logic               vs_s0;

    // Delay-line outputs, still active-high.
    logic               vid_d;
    logic               hs_d;
    logic               vs_d;

    // Next raster position and its decode; the decode is taken from the
    // next state so the registered copy lines up with pixel_x/pixel_y.
    always_comb begin
        advance  = enable && (div_cnt == DIV_LAST);
        h_wrap   = (h_cnt == H_LAST);
        v_wrap   = (v_cnt == V_LAST);
        h_next   = h_cnt;
        v_next   = v_cnt;
        if (advance) begin
            h_next = h_wrap ? '0 : (h_cnt + COORD_ONE);
            if (h_wrap) begin
                v_next = v_wrap ? '0 : (v_cnt + COORD_ONE);
            end
        end
        vid_next = (h_next < H_ACT_END) && (v_next < V_ACT_END);
        hs_next  = (h_next >= HS_FIRST) && (h_next <= HS_LAST);
        vs_next  = (v_next >= VS_FIRST) && (v_next <= VS_LAST);
    end

    // Divider, raster counters, pixel strobe, line/frame strobes and frame count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            div_cnt     <= '0;
            h_cnt       <= '0;
            v_cnt       <= '0;
            frame_cnt   <= '0;
            p_tick      <= 1'b0;
            line_start  <= 1'b0;
            frame_start <= 1'b0;
        end else begin
            if (enable) begin
                div_cnt <= (div_cnt == DIV_LAST) ? '0 : (div_cnt + DIV_ONE);
            end
            h_cnt       <= h_next;
            v_cnt       <= v_next;
            p_tick      <= advance;
            line_start  <= advance && h_wrap;
            frame_start <= advance && h_wrap && v_wrap;
            if (advance && h_wrap && v_wrap) begin
                frame_cnt <= frame_cnt + FRAME_ONE;
            end
        end
    end

    // First stage of sync/blank, aligned with the counter registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            vid_s0 <= 1'b0;
            hs_s0  <= 1'b0;
            vs_s0  <= 1'b0;
        end else begin
            vid_s0 <= vid_next;
            hs_s0  <= hs_next;
            vs_s0  <= vs_next;
        end
    end

    // Optional extra delay; it shifts every clk, even while frozen, so the
    // delayed outputs drain to the frozen decode.
    generate
        if (SYNC_DELAY > 0) begin : g_delay
            logic [SYNC_DELAY-1:0] vid_sr;
            logic [SYNC_DELAY-1:0] hs_sr;
            logic [SYNC_DELAY-1:0] vs_sr;

            // Shift register, reset to the inactive level.
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    vid_sr <= '0;
                    hs_sr  <= '0;
                    vs_sr  <= '0;
                end else begin
                    vid_sr[0] <= vid_s0;
                    hs_sr[0]  <= hs_s0;
                    vs_sr[0]  <= vs_s0;
                    for (int i = 1; i < SYNC_DELAY; i++) begin
                        vid_sr[i] <= vid_sr[i-1];
                        hs_sr[i]  <= hs_sr[i-1];
                        vs_sr[i]  <= vs_sr[i-1];
                    end
                end
            end

            assign vid_d = vid_sr[SYNC_DELAY-1];
            assign hs_d  = hs_sr[SYNC_DELAY-1];
            assign vs_d  = vs_sr[SYNC_DELAY-1];
        end else begin : g_no_delay
            assign vid_d = vid_s0;
            assign hs_d  = hs_s0;
            assign vs_d  = vs_s0;
        end
    endgenerate

    // Pin polarity is a fixed inversion of the registered active-high flags.
    assign video_on = vid_d;
    assign hsync    = (HS_ACT_LOW != 0) ? ~hs_d : hs_d;
    assign vsync    = (VS_ACT_LOW != 0) ? ~vs_d : vs_d;
    assign pixel_x  = h_cnt;
    assign pixel_y  = v_cnt;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_gen.sv
`default_nettype none
// ============================================================================
//  Module      : tb_vga_timing_gen
//  Description : Self-checking bench for vga_timing_gen. Four instances share
//                clock, reset and enable: default mode, default with a 3-clk
//                sync delay, DIV=1 with active-high syncs, and a tiny 16x8
//                mode with a 2-bit frame counter.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_vga_timing_gen;

    logic clk;
    logic reset_n;
    logic enable;

    logic       a_tick, a_vid, a_hs, a_vs, a_ls, a_fs;
    logic [9:0] a_x, a_y;
    logic [7:0] a_fc;
    logic       b_tick, b_vid, b_hs, b_vs, b_ls, b_fs;
    logic [9:0] b_x, b_y;
    logic [7:0] b_fc;
    logic       c_tick, c_vid, c_hs, c_vs, c_ls, c_fs;
    logic [9:0] c_x, c_y;
    logic [7:0] c_fc;
    logic       d_tick, d_vid, d_hs, d_vs, d_ls, d_fs;
    logic [9:0] d_x, d_y;
    logic [1:0] d_fc;

    int pass_cnt  = 0;
    int total_cnt = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    vga_timing_gen u_a (
        .clk(clk), .reset_n(reset_n), .enable(enable), .p_tick(a_tick),
        .pixel_x(a_x), .pixel_y(a_y), .video_on(a_vid), .hsync(a_hs),
        .vsync(a_vs), .line_start(a_ls), .frame_start(a_fs), .frame_cnt(a_fc)
    );

    vga_timing_gen #(.SYNC_DELAY(3)) u_b (
        .clk(clk), .reset_n(reset_n), .enable(enable), .p_tick(b_tick),
        .pixel_x(b_x), .pixel_y(b_y), .video_on(b_vid), .hsync(b_hs),
        .vsync(b_vs), .line_start(b_ls), .frame_start(b_fs), .frame_cnt(b_fc)
    );

    vga_timing_gen #(.DIV(1), .HS_ACT_LOW(0), .VS_ACT_LOW(0)) u_c (
        .clk(clk), .reset_n(reset_n), .enable(enable), .p_tick(c_tick),
        .pixel_x(c_x), .pixel_y(c_y), .video_on(c_vid), .hsync(c_hs),
        .vsync(c_vs), .line_start(c_ls), .frame_start(c_fs), .frame_cnt(c_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(4), .V_FP(1), .V_SYNC(1), .V_BP(2),
        .DIV(2), .FRAME_W(2)
    ) u_d (
        .clk(clk), .reset_n(reset_n), .enable(enable), .p_tick(d_tick),
        .pixel_x(d_x), .pixel_y(d_y), .video_on(d_vid), .hsync(d_hs),
        .vsync(d_vs), .line_start(d_ls), .frame_start(d_fs), .frame_cnt(d_fc)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h expected %0h", name, act, exp);
    endtask

    // Edge k counts rising edges after reset release; values sampled 1 ns after.
    typedef struct {
        int k;
        int x;  int y;  bit tick; bit ls; bit vid; bit hs;   // default instance
        bit vid_d; bit hs_d;                                  // 3-clk delayed instance
        int cx; bit chs;                                      // DIV=1 active-high instance
    } vec_t;

    vec_t vecs[20];

    initial begin
        int k;
        int bad_bx, bad_ct, bad_cls, bad_chs, a_ls_n, a_tick_n, bad_frz;
        int bad_dxy, bad_dfc, bad_dvs, bad_dvid, bad_dfs, d_vid_ticks;

        vecs[0]  = '{1,    0,   0, 0, 0, 1, 1, 0, 1, 1,   0};
        vecs[1]  = '{2,    1,   0, 1, 0, 1, 1, 0, 1, 2,   0};
        vecs[2]  = '{4,    2,   0, 1, 0, 1, 1, 1, 1, 4,   0};
        vecs[3]  = '{1279, 639, 0, 0, 0, 1, 1, 1, 1, 479, 0};
        vecs[4]  = '{1282, 641, 0, 1, 0, 0, 1, 1, 1, 482, 0};
        vecs[5]  = '{1283, 641, 0, 0, 0, 0, 1, 0, 1, 483, 0};
        vecs[6]  = '{1312, 656, 0, 1, 0, 0, 0, 0, 1, 512, 0};
        vecs[7]  = '{1314, 657, 0, 1, 0, 0, 0, 0, 1, 514, 0};
        vecs[8]  = '{1315, 657, 0, 0, 0, 0, 0, 0, 0, 515, 0};
        vecs[9]  = '{1456, 728, 0, 1, 0, 0, 0, 0, 0, 656, 1};
        vecs[10] = '{1503, 751, 0, 0, 0, 0, 0, 0, 0, 703, 1};
        vecs[11] = '{1504, 752, 0, 1, 0, 0, 1, 0, 0, 704, 1};
        vecs[12] = '{1507, 753, 0, 0, 0, 0, 1, 0, 1, 707, 1};
        vecs[13] = '{1551, 775, 0, 0, 0, 0, 1, 0, 1, 751, 1};
        vecs[14] = '{1552, 776, 0, 1, 0, 0, 1, 0, 1, 752, 0};
        vecs[15] = '{1599, 799, 0, 0, 0, 0, 1, 0, 1, 799, 0};
        vecs[16] = '{1600, 0,   1, 1, 1, 1, 1, 0, 1, 0,   0};
        vecs[17] = '{1601, 0,   1, 0, 0, 1, 1, 0, 1, 1,   0};
        vecs[18] = '{1603, 1,   1, 0, 0, 1, 1, 1, 1, 3,   0};
        vecs[19] = '{3200, 0,   2, 1, 1, 1, 1, 0, 1, 0,   0};

        // ---- reset state ----
        enable  = 1'b1;
        reset_n = 1'b1;
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset_a_ctrl", {a_tick, a_ls, a_fs, a_vid, a_hs, a_vs}, 6'b000011);
        check("reset_a_cnt", {a_x, a_y, a_fc}, 28'd0);
        check("reset_c_pins", {c_tick, c_vid, c_hs, c_vs}, 4'b0000);
        check("reset_b_pins", {b_vid, b_hs, b_vs}, 3'b011);

        // ---- table-driven vectors from release ----
        @(negedge clk) reset_n = 1'b1;
        k = 0;
        foreach (vecs[i]) begin
            while (k < vecs[i].k) begin
                @(posedge clk);
                k++;
            end
            #1;
            check($sformatf("v%0d_a_x", i),    a_x,    vecs[i].x);
            check($sformatf("v%0d_a_y", i),    a_y,    vecs[i].y);
            check($sformatf("v%0d_a_tick", i), a_tick, vecs[i].tick);
            check($sformatf("v%0d_a_ls", i),   a_ls,   vecs[i].ls);
            check($sformatf("v%0d_a_vid", i),  a_vid,  vecs[i].vid);
            check($sformatf("v%0d_a_hs", i),   a_hs,   vecs[i].hs);
            check($sformatf("v%0d_b_vid", i),  b_vid,  vecs[i].vid_d);
            check($sformatf("v%0d_b_hs", i),   b_hs,   vecs[i].hs_d);
            check($sformatf("v%0d_c_x", i),    c_x,    vecs[i].cx);
            check($sformatf("v%0d_c_hs", i),   c_hs,   vecs[i].chs);
        end

        // ---- one full default line, per edge ----
        bad_bx = 0; bad_ct = 0; bad_cls = 0; bad_chs = 0; a_ls_n = 0; a_tick_n = 0;
        while (k < 4800) begin
            int cx;
            @(posedge clk);
            k++;
            #1;
            cx = k % 800;
            if (b_x !== 10'((k / 2) % 800)) bad_bx++;
            if (c_tick !== 1'b1) bad_ct++;
            if (c_ls !== (cx == 0)) bad_cls++;
            if (c_hs !== (cx >= 656 && cx <= 751)) bad_chs++;
            if (a_ls === 1'b1) a_ls_n++;
            if (a_tick === 1'b1) a_tick_n++;
        end
        check("b_pixel_x_undelayed", bad_bx, 0);
        check("c_tick_constant", bad_ct, 0);
        check("c_line_800", bad_cls, 0);
        check("c_hsync_high_window", bad_chs, 0);
        check("a_line_1600", a_ls_n, 1);
        check("a_tick_every_2nd", a_tick_n, 800);

        // ---- enable freeze at h_cnt=100 for 50 clk ----
        while (k < 5000) begin
            @(posedge clk);
            k++;
        end
        #1;
        check("frz_a_x_before", a_x, 100);
        check("frz_a_tick_before", a_tick, 1);
        enable = 1'b0;
        bad_frz = 0;
        repeat (50) begin
            @(posedge clk);
            #1;
            if (a_tick !== 1'b0 || a_x !== 10'd100 || a_ls !== 1'b0 || c_tick !== 1'b0) bad_frz++;
        end
        check("frz_hold", bad_frz, 0);
        check("frz_b_settled", {b_vid, b_hs}, 2'b11);
        check("frz_c_x", c_x, 200);
        enable = 1'b1;
        @(posedge clk);
        #1;
        check("resume_a_x0", {a_tick, a_x}, {1'b0, 10'd100});
        @(posedge clk);
        #1;
        check("resume_a_x1", {a_tick, a_x}, {1'b1, 10'd101});
        check("resume_c_x", c_x, 202);

        // ---- asynchronous reset mid-frame ----
        #3 reset_n = 1'b0;
        #1;
        check("async_rst_a_ctrl", {a_tick, a_ls, a_fs, a_vid, a_hs, a_vs}, 6'b000011);
        check("async_rst_a_cnt", {a_x, a_y, a_fc}, 28'd0);
        check("async_rst_c_cnt", {c_x, c_y}, 20'd0);
        @(posedge clk);
        #1;
        check("async_rst_held", {a_tick, a_x, d_x, d_y}, 31'd0);

        // ---- tiny mode: vsync line, active count, frame counter wrap ----
        @(negedge clk) reset_n = 1'b1;
        k = 0;
        bad_dxy = 0; bad_dfc = 0; bad_dvs = 0; bad_dvid = 0; bad_dfs = 0; d_vid_ticks = 0;
        while (k < 1100) begin
            int eh, ev;
            @(posedge clk);
            k++;
            #1;
            eh = (k / 2) % 16;
            ev = (k / 32) % 8;
            if (d_x !== 10'(eh) || d_y !== 10'(ev)) bad_dxy++;
            if (d_fc !== 2'((k / 256) % 4)) bad_dfc++;
            if (d_vs !== (ev != 5)) bad_dvs++;
            if (d_vid !== (eh < 8 && ev < 4)) bad_dvid++;
            if (d_fs !== (k % 256 == 0)) bad_dfs++;
            if (k > 256 && k <= 512 && d_tick === 1'b1 && d_vid === 1'b1) d_vid_ticks++;
            if (k == 1023) check("d_frame_cnt_3", d_fc, 3);
            if (k == 1024) check("d_frame_cnt_wrap", d_fc, 0);
        end
        check("d_counters", bad_dxy, 0);
        check("d_frame_cnt", bad_dfc, 0);
        check("d_vsync_line", bad_dvs, 0);
        check("d_video_on", bad_dvid, 0);
        check("d_frame_start", bad_dfs, 0);
        check("d_active_ticks", d_vid_ticks, 32);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
`default_nettype wire
